emif_calbus_tile_responder: RTL and testbench
=============================================

// Module: emif_calbus_tile_responder
// PURPOSE
//  Target end of one calbus channel: decodes calbus_read/calbus_write from the IOSSM calibration master.
//  Serves a 32-bit CSR bank and a 128-word sequencer parameter table, returned as calbus_seq_param_tbl.
//  Stands in for the IO-tile side in simulation and in the soft-NIOS flow; one instance per used channel.
// PARAMETERS
//  NUM_CSR         16    CSR words in region 0 (1..64)
//  RD_LATENCY      2     calbus_clk cycles from read strobe to valid calbus_rdata (1..4)
//  PTBL_WORDS      128   parameter-table words; 32*PTBL_WORDS = 4096 = calbus_seq_param_tbl width
//  UNMAPPED_RDATA  32'hDEAD_BEEF  read data for unmapped, illegal or not-ready accesses
// PORTS
//  calbus_clk              in   1     sole clock
//  calbus_reset            in   1     synchronous, active-high reset
//  calbus_read             in   1     read strobe, one cycle per access
//  calbus_write            in   1     write strobe, one cycle per access
//  calbus_address          in   20    [19:16] region, [15:0] word index
//  calbus_wdata            in   32    write data, sampled with calbus_write
//  calbus_rdata            out  32    read data, valid RD_LATENCY cycles after calbus_read
//  calbus_seq_param_tbl    out  4096  word i at bits [32*i+31:32*i]
//  resp_ready              out  1     high once post-reset table clear completes
//  resp_err_cnt            out  8     unmapped/illegal access count (present only with the macro below)
// BEHAVIOUR
//  Reset state: calbus_rdata=0, calbus_seq_param_tbl=0, resp_ready=0, CSRs=0, resp_err_cnt=0, FSM=CLEAR, clear index=0.
//  FSM has three states.
//   CLEAR: clears one table word per cycle, index 0..PTBL_WORDS-1, then moves to READY. Takes exactly PTBL_WORDS cycles.
//   READY: resp_ready=1 and accesses are served.
//   ERR: entered on simultaneous read and write. Lasts one cycle, then returns to READY.
//  Address decode is on [19:16]:
//   0x0: CSR, index < NUM_CSR.
//   0x1: table, index < PTBL_WORDS.
//   Anything else is unmapped.
//  Write, READY, mapped: the target word updates on the next edge. Unmapped writes are dropped and counted.
//  Read, READY, mapped: the value is sampled at the strobe edge and shifted through an RD_LATENCY-deep pipe.
//  Read-after-write to the same word in back-to-back cycles returns the new data (the write completes first).
//  Unmapped or not-ready read: UNMAPPED_RDATA after RD_LATENCY cycles; counted only if READY.
//  calbus_rdata holds its last value until the next read result reaches the pipe output.
//  Pipelined reads are accepted every cycle; no backpressure, no waitrequest.
//  Read and write in the same cycle: neither is performed. calbus_rdata gets UNMAPPED_RDATA at RD_LATENCY. FSM goes to ERR and the event is counted.
//  Any access during CLEAR: writes are dropped, reads return UNMAPPED_RDATA, and the clear continues uninterrupted.
//  Reset asserted mid-operation: the read pipe is flushed (rdata=0), and the FSM restarts CLEAR from index 0 on the next edge.
//  CSR word 0 is read-only ID 32'hCA1B_0001; writes to it are ignored and not counted.
//  calbus_seq_param_tbl is driven directly from table storage, so a write is visible one cycle after the strobe.
// CONFIGURATION
//  Macro EMIF_CALBUS_RESP_ERR_CNT_EN selects whether the error counter exists.
//  Defined:
//   resp_err_cnt is an 8-bit saturating counter (holds at 255).
//   It counts unmapped accesses in READY and read+write collisions.
//   CSR word 1 reads the counter; any write to CSR word 1 clears it.
//  Undefined:
//   There is no counter.
//   resp_err_cnt is tied to 0.
//   CSR word 1 is an ordinary read/write register.
// TESTING
//  Reset, then poll: resp_ready rises exactly 128 cycles after reset deasserts; reading table word 5 returns 0.
//  READY: write region 1 word 7 = 32'h1234_5678 -> calbus_seq_param_tbl[255:224]=32'h1234_5678 next cycle; read word 7 returns it at latency 2.
//  Back-to-back reads of CSR 2, 3, 4 (values A, B, C) on consecutive cycles -> rdata A, B, C on cycles 2, 3, 4.
//  Read address 20'h3_0000 -> 32'hDEAD_BEEF at latency 2; resp_err_cnt 0->1 (macro defined).
//  Read and write in the same cycle -> target word unchanged, rdata 32'hDEAD_BEEF, err_cnt +1; 300 collisions -> counter at 255.
//  Assert reset mid-CLEAR (index 60) -> rdata=0, resp_ready stays 0, and a full 128-cycle clear runs again.

Source files
------------

// File: rtl/emif_calbus_tile_responder.sv
// emif_calbus_tile_responder
// Target end of one calbus channel. It serves a CSR bank in region 0 and a
// sequencer parameter table in region 1. The table is exported as the
// flat calbus_seq_param_tbl bus.
// Optional feature: define EMIF_CALBUS_RESP_ERR_CNT_EN to build the
// saturating error counter. When it is built, CSR word 1 reads the counter
// and any write to CSR word 1 clears it.
module emif_calbus_tile_responder #(
  parameter int unsigned NUM_CSR        = 16,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned PTBL_WORDS     = 128,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF
) (
  input  logic                    calbus_clk,
  input  logic                    calbus_reset,
  input  logic                    calbus_read,
  input  logic                    calbus_write,
  input  logic [19:0]             calbus_address,
  input  logic [31:0]             calbus_wdata,
  output logic [31:0]             calbus_rdata,
  output logic [32*PTBL_WORDS-1:0] calbus_seq_param_tbl,
  output logic                    resp_ready,
  output logic [7:0]              resp_err_cnt
);

  localparam logic [1:0]  ST_CLEAR = 2'd0;
  localparam logic [1:0]  ST_READY = 2'd1;
  localparam logic [1:0]  ST_ERR   = 2'd2;
  localparam int unsigned TW       = (PTBL_WORDS > 1) ? $clog2(PTBL_WORDS) : 1;
  localparam int unsigned CW       = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam logic [31:0] CSR_ID   = 32'hCA1B_0001;

  logic [1:0]              state_q, state_d;
  logic [TW-1:0]           clr_idx_q, clr_idx_d;
  logic [32*PTBL_WORDS-1:0] tbl_q;
  logic [31:0]             csr_q [NUM_CSR];
  logic [31:0]             rdata_q;
  logic [7:0]              err_cnt_q;

  logic [31:0]   idx32;
  logic [CW-1:0] csr_sel;
  logic [TW-1:0] tbl_sel;
  logic          csr_hit, tbl_hit, mapped, is_ready;
  logic          do_wr, do_rd, unmapped_evt, collide_evt;
  logic [31:0]   rd_val;
  logic          tail_v;
  logic [31:0]   tail_d;

  assign idx32   = {16'd0, calbus_address[15:0]};
  assign csr_sel = calbus_address[CW-1:0];
  assign tbl_sel = calbus_address[TW-1:0];
  assign csr_hit = (calbus_address[19:16] == 4'h0) && (idx32 < NUM_CSR);
  assign tbl_hit = (calbus_address[19:16] == 4'h1) && (idx32 < PTBL_WORDS);
  assign mapped  = csr_hit | tbl_hit;
  assign is_ready = (state_q == ST_READY);

  assign do_wr        = is_ready & calbus_write & ~calbus_read & mapped;
  assign do_rd        = is_ready & calbus_read & ~calbus_write & mapped;
  assign unmapped_evt = is_ready & (calbus_read ^ calbus_write) & ~mapped;
  // A collision still counts when it lands in ERR, but never during CLEAR.
  assign collide_evt  = calbus_read & calbus_write & (state_q != ST_CLEAR);

  assign calbus_seq_param_tbl = tbl_q;
  assign calbus_rdata         = rdata_q;
  assign resp_ready           = (state_q != ST_CLEAR);

  // Select the read value that is sampled at the strobe edge.
  always_comb begin
    rd_val = UNMAPPED_RDATA;
    if (do_rd) begin
      if (csr_hit) begin
        if (csr_sel == '0) begin
          rd_val = CSR_ID;
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
        end else if (csr_sel == CW'(1)) begin
          rd_val = {24'd0, err_cnt_q};
`endif
        end else begin
          rd_val = csr_q[csr_sel];
        end
      end else begin
        rd_val = tbl_q[{tbl_sel, 5'd0} +: 32];
      end
    end
  end

  // Next state for the CLEAR, READY and ERR sequencing and the clear index.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == TW'(PTBL_WORDS - 1)) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end
      end
      ST_READY: if (calbus_read && calbus_write) state_d = ST_ERR;
      ST_ERR:   state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // FSM and clear index registers.
  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Table storage: zeroed one word per cycle in CLEAR, or written when READY.
  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      tbl_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      tbl_q[{clr_idx_q, 5'd0} +: 32] <= '0;
    end else if (do_wr && tbl_hit) begin
      tbl_q[{tbl_sel, 5'd0} +: 32] <= calbus_wdata;
    end
  end

  // CSR bank. Word 0 is the fixed ID and is never written.
  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      for (int unsigned i = 0; i < NUM_CSR; i++) csr_q[i] <= '0;
    end else if (do_wr && csr_hit && (csr_sel != '0)) begin
      csr_q[csr_sel] <= calbus_wdata;
    end
  end

  // The read pipe has RD_LATENCY-1 stages ahead of the holding rdata register.
  generate
    if (RD_LATENCY == 1) begin : g_nopipe
      assign tail_v = calbus_read;
      assign tail_d = rd_val;
    end else begin : g_pipe
      logic [RD_LATENCY-2:0] pv_q;
      logic [31:0]           pd_q [RD_LATENCY-1];

      // Shift read results towards the rdata register.
      always_ff @(posedge calbus_clk) begin
        if (calbus_reset) begin
          pv_q <= '0;
          for (int unsigned i = 0; i < RD_LATENCY - 1; i++) pd_q[i] <= '0;
        end else begin
          pv_q[0] <= calbus_read;
          pd_q[0] <= rd_val;
          for (int unsigned i = 1; i < RD_LATENCY - 1; i++) begin
            pv_q[i] <= pv_q[i-1];
            pd_q[i] <= pd_q[i-1];
          end
        end
      end

      assign tail_v = pv_q[RD_LATENCY-2];
      assign tail_d = pd_q[RD_LATENCY-2];
    end
  endgenerate

  // rdata keeps its value until a new read result leaves the pipe.
  always_ff @(posedge calbus_clk) begin
    if (calbus_reset)  rdata_q <= '0;
    else if (tail_v)   rdata_q <= tail_d;
  end

`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
  // Saturating error counter. A write to CSR word 1 clears it.
  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      err_cnt_q <= '0;
    end else if (do_wr && csr_hit && (csr_sel == CW'(1))) begin
      err_cnt_q <= '0;
    end else if ((unmapped_evt || collide_evt) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
  assign resp_err_cnt = err_cnt_q;
`else
  assign err_cnt_q    = '0;
  assign resp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_emif_calbus_tile_responder.sv
// Bench for emif_calbus_tile_responder. It uses directed accesses and keeps
// a behavioural model of the address map, the read latency and the error
// count. Outputs are compared against the model on every falling edge.
// The counter expectations follow EMIF_CALBUS_RESP_ERR_CNT_EN.
module tb_emif_calbus_tile_responder;

  localparam int          LAT   = 2;
  localparam int          NW    = 128;
  localparam int          NC    = 16;
  localparam logic [31:0] UNMAP = 32'hDEAD_BEEF;
  localparam logic [31:0] ID    = 32'hCA1B_0001;

  logic          clk = 1'b0;
  logic          rst, rd, wr;
  logic [19:0]   addr;
  logic [31:0]   wdata, rdata;
  logic [32*NW-1:0] tbl;
  logic          ready;
  logic [7:0]    err_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  emif_calbus_tile_responder #(
    .NUM_CSR(NC), .RD_LATENCY(LAT), .PTBL_WORDS(NW), .UNMAPPED_RDATA(UNMAP)
  ) dut (
    .calbus_clk(clk), .calbus_reset(rst), .calbus_read(rd), .calbus_write(wr),
    .calbus_address(addr), .calbus_wdata(wdata), .calbus_rdata(rdata),
    .calbus_seq_param_tbl(tbl), .resp_ready(ready), .resp_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [31:0] val; } pend_t;
  pend_t       pq[$];
  logic [31:0] m_tbl [NW];
  logic [31:0] m_csr [NC];
  int          clear_left;
  int          m_cnt;
  bit          in_err;
  logic [31:0] exp_rdata;
  int          edge_n = 0;

  always @(posedge clk) begin
    logic [31:0] r;
    int  idx;
    bit  served, rdy, chit, thit, nerr;
    if (rst) begin
      clear_left = NW; in_err = 0; m_cnt = 0; exp_rdata = 0;
      for (int i = 0; i < NW; i++) m_tbl[i] = 0;
      for (int i = 0; i < NC; i++) m_csr[i] = 0;
      pq.delete();
    end else begin
      rdy    = (clear_left == 0);
      served = rdy && !in_err;
      idx    = int'(addr[15:0]);
      chit   = (addr[19:16] == 4'h0) && idx < NC;
      thit   = (addr[19:16] == 4'h1) && idx < NW;
      r      = UNMAP;
      nerr   = 0;
      if (rd && wr) begin
        if (rdy && m_cnt < 255) m_cnt++;
        nerr = served;
      end else begin
        if (rd && served) begin
          if (chit) begin
            if (idx == 0) r = ID;
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
            else if (idx == 1) r = 32'(m_cnt);
`endif
            else r = m_csr[idx];
          end else if (thit) r = m_tbl[idx];
          else if (m_cnt < 255) m_cnt++;
        end
        if (wr && served) begin
          if (chit) begin
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
            if (idx == 1) m_cnt = 0;
`endif
            if (idx != 0) m_csr[idx] = wdata;
          end else if (thit) m_tbl[idx] = wdata;
          else if (m_cnt < 255) m_cnt++;
        end
      end
      if (rd) pq.push_back('{due: edge_n + LAT - 1, val: r});
      if (clear_left > 0) clear_left--;
      in_err = nerr;
      while (pq.size() > 0 && pq[0].due == edge_n) begin
        exp_rdata = pq[0].val;
        void'(pq.pop_front());
      end
    end
    edge_n++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      int wi;
      bad = -1;
      chk("rdata", rdata, exp_rdata);
      chk("ready", {31'd0, ready}, {31'd0, clear_left == 0});
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
      chk("err_cnt", {24'd0, err_cnt}, 32'(m_cnt));
`else
      chk("err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
      for (int i = 0; i < NW; i++)
        if (bad < 0 && tbl[i*32 +: 32] !== m_tbl[i]) bad = i;
      wi = (bad < 0) ? 0 : bad;
      chk("tbl_word", tbl[wi*32 +: 32], m_tbl[wi]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic r, input logic w, input logic [19:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    idle(3);
    chk_en = 1'b1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_tbl", tbl[31:0], 32'd0);
    rst = 1'b0;
    wait_ready(n);
    chk("ready_latency", n, 128);

    drv(1, 0, 20'h1_0005, 0); idle(1);
    chk("tbl5_read", rdata, 32'd0);

    drv(0, 1, 20'h1_0007, 32'h1234_5678);
    chk("tbl7_bus", tbl[255:224], 32'h1234_5678);
    drv(1, 0, 20'h1_0007, 0);
    chk("tbl7_not_lat1", rdata, 32'd0);
    idle(1);
    chk("tbl7_read", rdata, 32'h1234_5678);

    drv(0, 1, 20'h0_0002, 32'hAAAA_0002);
    drv(0, 1, 20'h0_0003, 32'hBBBB_0003);
    drv(0, 1, 20'h0_0004, 32'hCCCC_0004);
    drv(1, 0, 20'h0_0002, 0);
    drv(1, 0, 20'h0_0003, 0);
    chk("b2b_A", rdata, 32'hAAAA_0002);
    drv(1, 0, 20'h0_0004, 0);
    chk("b2b_B", rdata, 32'hBBBB_0003);
    idle(1);
    chk("b2b_C", rdata, 32'hCCCC_0004);

    drv(0, 1, 20'h0_0000, 32'h0BAD_0BAD);
    drv(1, 0, 20'h0_0000, 0); idle(1);
    chk("csr0_id", rdata, ID);

    drv(0, 1, 20'h0_0001, 32'h0000_0055);
    drv(1, 0, 20'h0_0001, 0); idle(1);
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
    chk("csr1_cnt", rdata, 32'd0);
`else
    chk("csr1_rw", rdata, 32'h0000_0055);
`endif

    drv(1, 0, 20'h3_0000, 0); idle(1);
    chk("unmapped_rd", rdata, UNMAP);
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
    chk("cnt_after_unmapped", {24'd0, err_cnt}, 32'd1);
`else
    chk("cnt_tied", {24'd0, err_cnt}, 32'd0);
`endif
    drv(0, 1, 20'h0_0010, 32'h1111_1111);
    drv(1, 0, 20'h1_0080, 0);
    drv(0, 1, 20'hF_0001, 32'h2222_2222);

    drv(0, 1, 20'h1_0009, 32'h9999_0009);
    drv(1, 0, 20'h1_0009, 0); idle(1);
    chk("raw_read", rdata, 32'h9999_0009);

    drv(1, 1, 20'h1_0007, 32'hFFFF_FFFF); idle(1);
    chk("collide_rdata", rdata, UNMAP);
    chk("collide_keep", tbl[255:224], 32'h1234_5678);

    repeat (300) begin
      drv(1, 1, 20'h0_0002, 32'h0);
      idle(1);
    end
`ifdef EMIF_CALBUS_RESP_ERR_CNT_EN
    chk("cnt_saturate", {24'd0, err_cnt}, 32'd255);
`else
    chk("cnt_still_0", {24'd0, err_cnt}, 32'd0);
`endif
    drv(1, 0, 20'h0_0002, 0); idle(1);
    chk("csr2_kept", rdata, 32'hAAAA_0002);

    rst = 1'b1; idle(2); rst = 1'b0;
    idle(57);
    drv(1, 0, 20'h1_0005, 0);
    drv(0, 1, 20'h1_0003, 32'h3333_3333);
    drv(1, 0, 20'h1_0007, 0);
    chk("clear_rd_unmap", rdata, UNMAP);
    rst = 1'b1; idle(1);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    wait_ready(n);
    chk("reclear_latency", n, 128);
    chk("tbl3_dropped", tbl[127:96], 32'd0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
